// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one op, issues at most one memory request,
// then presents the aligned/extended result on the writeback handshake.
module lsu_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_isLoad,
  input  logic        in_isStore,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_exc
);

  // state | meaning
  // IDLE  | ready for a new op
  // REQ   | memory request presented, waiting for mem_req_ready
  // WAIT  | request accepted, waiting for mem_resp_valid
  // DONE  | result presented, waiting for out_ready
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        is_store_q;
  logic [4:0]  rd_q;
  logic        mem_wen_q;
  logic [31:0] mem_addr_q;
  logic [3:0]  mem_wmask_q;
  logic [31:0] mem_wdata_q;
  logic [31:0] out_data_q;
  logic [4:0]  out_rd_q;
  logic        out_exc_q;

  logic        load_ok;
  logic        store_ok;
  logic        pass_thru;
  logic        misaligned;
  logic        go_mem;
  logic [3:0]  st_mask;
  logic [31:0] st_data;
  logic [31:0] lane;
  logic [31:0] load_result;

  always_comb begin
    load_ok   = 1'b0;
    store_ok  = 1'b0;
    pass_thru = ~in_isLoad & ~in_isStore;
    if (in_isLoad && !in_isStore) begin
      load_ok = (in_funct3 == 3'd0) || (in_funct3 == 3'd1) || (in_funct3 == 3'd2) ||
                (in_funct3 == 3'd4) || (in_funct3 == 3'd5);
    end
    if (in_isStore && !in_isLoad) begin
      store_ok = (in_funct3 == 3'd0) || (in_funct3 == 3'd1) || (in_funct3 == 3'd2);
    end
    // funct3[1:0] encodes access size for every legal code (B/BU=0, H/HU=1, W=2)
    case (in_funct3[1:0])
      2'b01:   misaligned = in_addr[0];
      2'b10:   misaligned = |in_addr[1:0];
      default: misaligned = 1'b0;
    endcase
    go_mem = (load_ok | store_ok) & ~misaligned;
    case (in_funct3[1:0])
      2'b00: begin
        st_mask = 4'b0001 << in_addr[1:0];
        st_data = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        st_mask = 4'b0011 << in_addr[1:0];
        st_data = {2{in_wdata[15:0]}};
      end
      default: begin
        st_mask = 4'b1111;
        st_data = in_wdata;
      end
    endcase
  end

  always_comb begin
    lane = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    load_result = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_result = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_result = {24'd0, lane[7:0]};
      3'd5:    load_result = {16'd0, lane[15:0]};
      default: load_result = mem_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      funct3_q    <= 3'd0;
      off_q       <= 2'd0;
      is_store_q  <= 1'b0;
      rd_q        <= 5'd0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= 32'd0;
      mem_wmask_q <= 4'd0;
      mem_wdata_q <= 32'd0;
      out_data_q  <= 32'd0;
      out_rd_q    <= 5'd0;
      out_exc_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            funct3_q   <= in_funct3;
            off_q      <= in_addr[1:0];
            is_store_q <= in_isStore;
            rd_q       <= in_rd;
            if (go_mem) begin
              mem_wen_q   <= in_isStore;
              mem_addr_q  <= {in_addr[31:2], 2'b00};
              mem_wmask_q <= in_isStore ? st_mask : 4'b0000;
              mem_wdata_q <= in_isStore ? st_data : 32'd0;
              state       <= S_REQ;
            end else begin
              out_data_q <= in_addr;
              out_rd_q   <= in_rd;
              out_exc_q  <= ~pass_thru;
              state      <= S_DONE;
            end
          end
        end
        S_REQ: begin
          if (mem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (mem_resp_valid) begin
            out_data_q <= is_store_q ? 32'd0 : load_result;
            out_rd_q   <= is_store_q ? 5'd0 : rd_q;
            out_exc_q  <= 1'b0;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state == S_IDLE);
  assign mem_req_valid = (state == S_REQ);
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wmask     = mem_wmask_q;
  assign mem_wdata     = mem_wdata_q;
  assign out_valid     = (state == S_DONE);
  assign out_data      = out_data_q;
  assign out_rd        = out_rd_q;
  assign out_exc       = out_exc_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: stimulus pushes model predictions, memory and
// writeback monitors pop and compare while driving random backpressure.
module tb_lsu_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        exc;
    bit          immed;
    int          acc_cyc;
  } exp_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
  } mem_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_isLoad = 1'b0;
  logic        in_isStore = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_addr = 32'd0;
  logic [31:0] in_wdata = 32'd0;
  logic [4:0]  in_rd = 5'd0;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_exc;

  bit          sb_en = 1'b0;
  logic        sb_req_ready = 1'b0, sb_resp_valid = 1'b0, sb_out_ready = 1'b0;
  logic [31:0] sb_rdata = 32'd0;
  logic        man_req_ready = 1'b0, man_resp_valid = 1'b0, man_out_ready = 1'b0;
  logic [31:0] man_rdata = 32'd0;

  assign mem_req_ready  = sb_en ? sb_req_ready  : man_req_ready;
  assign mem_resp_valid = sb_en ? sb_resp_valid : man_resp_valid;
  assign mem_rdata      = sb_en ? sb_rdata      : man_rdata;
  assign out_ready      = sb_en ? sb_out_ready  : man_out_ready;

  lsu_ctrl dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_isLoad(in_isLoad), .in_isStore(in_isStore), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata), .in_rd(in_rd),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .out_exc(out_exc)
  );

  always #5 clock = ~clock;

  int   nchk = 0, nfail = 0;
  int   cyc = 0;
  int   nops = 0, nreq = 0, nwb = 0;
  int   req_wait = -1, out_wait = -1;
  exp_t exp_q[$];
  mem_t mem_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nchk++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    nchk++;
    nfail++;
    $display("FAIL %s", name);
  endtask

  function automatic bit [31:0] rdata_of(input bit [31:0] wa);
    if (wa == 32'h80000000) return 32'h80FF1234;
    return (wa * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  // Reference behaviour from the size/sign rules, with plain arithmetic.
  function automatic void model(input bit ld, input bit st, input bit [2:0] f3,
                                input bit [31:0] a, input bit [31:0] wd, input bit [4:0] rd,
                                output exp_t e, output mem_t m, output bit has_mem);
    int size;
    bit sgn;
    bit [31:0] v, lim;
    e = '0; m = '0; has_mem = 0;
    e.rd = rd; e.data = a; e.immed = 1;
    size = 0; sgn = 0;
    if (ld && !st) begin
      case (f3)
        3'd0: begin size = 1; sgn = 1; end
        3'd1: begin size = 2; sgn = 1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: size = 0;
      endcase
    end else if (st && !ld) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: size = 0;
      endcase
    end
    if (!ld && !st) return;
    if (size == 0 || (a % size) != 0) begin
      e.exc = 1;
      return;
    end
    has_mem = 1;
    e.immed = 0;
    m.addr = a - (a % 4);
    m.wen = st;
    if (st) begin
      m.wmask = 4'(((1 << size) - 1) << (a % 4));
      if (size == 1)      m.wdata = (wd & 32'hFF) * 32'h01010101;
      else if (size == 2) m.wdata = (wd & 32'hFFFF) * 32'h00010001;
      else                m.wdata = wd;
      e.data = 0;
      e.rd = 0;
    end else begin
      v = rdata_of(m.addr) >> (8 * (a % 4));
      if (size < 4) begin
        lim = 32'd1 << (8 * size);
        v = v % lim;
        if (sgn && v >= lim / 2) v = v - lim;
      end
      e.data = v;
    end
  endfunction

  task automatic issue(input bit ld, input bit st, input bit [2:0] f3,
                       input bit [31:0] a, input bit [31:0] wd, input bit [4:0] rd);
    exp_t e; mem_t m; bit hm; int budget;
    model(ld, st, f3, a, wd, rd, e, m, hm);
    @(negedge clock);
    in_valid = 1; in_isLoad = ld; in_isStore = st; in_funct3 = f3;
    in_addr = a; in_wdata = wd; in_rd = rd;
    budget = 0;
    while (!in_ready && budget < 200) begin
      @(negedge clock);
      budget++;
    end
    if (!in_ready) begin
      in_valid = 0;
      fail_now("accept_timeout");
      return;
    end
    e.acc_cyc = cyc + 1;
    exp_q.push_back(e);
    if (hm) mem_q.push_back(m);
    nops++;
    @(posedge clock);
    #1 in_valid = 0;
  endtask

  // Memory side: checks request fields every cycle they are presented,
  // applies ready backpressure, answers later, and injects stray responses.
  bit          pending = 0, in_req = 0;
  int          wait_cnt = 0, resp_cnt = 0;
  logic [31:0] pend_rdata = 0;
  always @(negedge clock) begin
    sb_resp_valid = 0;
    sb_req_ready  = 0;
    sb_rdata      = $urandom;
    if (sb_en) begin
      if (pending) begin
        if (resp_cnt == 0) begin
          sb_resp_valid = 1;
          sb_rdata = pend_rdata;
          pending = 0;
        end else resp_cnt--;
      end else if ($urandom_range(0, 7) == 0) begin
        sb_resp_valid = 1;
      end
      if (mem_req_valid) begin
        if (mem_q.size() == 0) fail_now("unexpected_mem_req");
        else begin
          chk("mem_wen", {31'd0, mem_wen}, {31'd0, mem_q[0].wen});
          chk("mem_addr", mem_addr, mem_q[0].addr);
          chk("mem_wmask", {28'd0, mem_wmask}, {28'd0, mem_q[0].wmask});
          chk("mem_wdata", mem_wdata, mem_q[0].wdata);
          if (!in_req) begin
            in_req = 1;
            wait_cnt = (req_wait < 0) ? $urandom_range(0, 3) : req_wait;
          end
          if (wait_cnt == 0) begin
            sb_req_ready = 1;
            pending = 1;
            resp_cnt = $urandom_range(0, 3);
            pend_rdata = rdata_of(mem_q[0].addr);
            void'(mem_q.pop_front());
            in_req = 0;
            nreq++;
          end else wait_cnt--;
        end
      end
    end
  end

  // Writeback side: compares every cycle out_valid is held, checks immediate
  // latency on the first cycle, and pops on the handshake it grants.
  bit wb_active = 0;
  int ord_cnt = 0;
  always @(negedge clock) begin
    sb_out_ready = 0;
    if (sb_en && out_valid) begin
      if (exp_q.size() == 0) fail_now("unexpected_out_valid");
      else begin
        chk("out_data", out_data, exp_q[0].data);
        chk("out_rd", {27'd0, out_rd}, {27'd0, exp_q[0].rd});
        chk("out_exc", {31'd0, out_exc}, {31'd0, exp_q[0].exc});
        if (!wb_active) begin
          wb_active = 1;
          if (exp_q[0].immed) chk("immediate_latency", cyc, exp_q[0].acc_cyc);
          ord_cnt = (out_wait < 0) ? $urandom_range(0, 2) : out_wait;
        end
        if (ord_cnt == 0) begin
          sb_out_ready = 1;
          void'(exp_q.pop_front());
          wb_active = 0;
          nwb++;
        end else ord_cnt--;
      end
    end
  end

  task automatic drain();
    int budget = 0;
    while ((exp_q.size() != 0 || mem_q.size() != 0 || pending) && budget < 2000) begin
      @(negedge clock);
      budget++;
    end
    if (budget >= 2000) fail_now("drain_timeout");
    repeat (2) @(negedge clock);
  endtask

  initial begin
    int r, q0, w0;
    bit ld, st;
    bit [2:0] f3;
    bit [2:0] lf3 [5];
    lf3[0] = 0; lf3[1] = 1; lf3[2] = 2; lf3[3] = 4; lf3[4] = 5;

    #1;
    chk("rst_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    repeat (2) @(negedge clock);
    reset = 0;
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    sb_en = 1;

    issue(1, 0, 3'd0, 32'h80000003, 32'h0, 5'd7);      // LB sign-extend
    issue(0, 1, 3'd1, 32'h80000102, 32'h0000ABCD, 5'd9);  // SH upper half
    issue(1, 0, 3'd2, 32'h80000002, 32'h0, 5'd3);      // LW misaligned
    issue(0, 0, 3'd0, 32'h12345678, 32'h0, 5'd11);     // pass-through
    drain();

    q0 = nreq; w0 = nwb;
    req_wait = 3; out_wait = 2;
    issue(1, 0, 3'd2, 32'h00001000, 32'h0, 5'd4);
    drain();
    req_wait = -1; out_wait = -1;
    chk("stall_one_request", nreq - q0, 32'd1);
    chk("stall_one_writeback", nwb - w0, 32'd1);

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      ld = (r <= 3) || (r == 7);
      st = (r >= 4 && r <= 7);
      if ($urandom_range(0, 7) == 0) f3 = 3'($urandom);
      else if (st && !ld) f3 = 3'($urandom_range(0, 2));
      else f3 = lf3[$urandom_range(0, 4)];
      issue(ld, st, f3, $urandom, $urandom, 5'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clock);
    end
    drain();
    chk("all_ops_written_back", nwb, nops);

    // Reset while waiting for a response, then a late response after release.
    sb_en = 0;
    @(negedge clock);
    in_valid = 1; in_isLoad = 1; in_isStore = 0; in_funct3 = 3'd2;
    in_addr = 32'h00000100; in_rd = 5'd6;
    @(posedge clock);
    #1 in_valid = 0;
    @(negedge clock);
    chk("rw_req_valid", {31'd0, mem_req_valid}, 32'd1);
    chk("rw_req_addr", mem_addr, 32'h00000100);
    man_req_ready = 1;
    @(negedge clock);
    man_req_ready = 0;
    reset = 1;
    #1;
    chk("rw_mem_addr", mem_addr, 32'd0);
    chk("rw_mem_wmask", {28'd0, mem_wmask}, 32'd0);
    chk("rw_mem_wdata", mem_wdata, 32'd0);
    chk("rw_mem_wen", {31'd0, mem_wen}, 32'd0);
    chk("rw_mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rw_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rw_out_data", out_data, 32'd0);
    chk("rw_out_rd", {27'd0, out_rd}, 32'd0);
    chk("rw_out_exc", {31'd0, out_exc}, 32'd0);
    @(negedge clock);
    reset = 0;
    @(negedge clock);
    man_resp_valid = 1; man_rdata = 32'hDEADBEEF;
    chk("rw_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clock);
    man_resp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("late_resp_no_out_valid", {31'd0, out_valid}, 32'd0);
      @(negedge clock);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameters: none; all widths fixed as listed.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 in_valid  in  1  upstream op valid.
REQ-005 in_ready  out  1  lsu_ctrl can accept an op.
REQ-006 in_isLoad / in_isStore  in  1 each  op class.
REQ-007 in_funct3  in  3  size code: 0 B, 1 H, 2 W, 4 BU, 5 HU (loads); 0 B, 1 H, 2 W (stores).
REQ-008 in_addr  in  32  byte address, or pass-through result for non-memory ops.
REQ-009 in_wdata  in  32  store data, right-aligned.
REQ-010 in_rd  in  5  destination register tag.
REQ-011 mem_req_valid  out  1; mem_req_ready  in  1  memory request handshake.
REQ-012 mem_wen  out  1; mem_addr  out  32 (word aligned); mem_wmask  out  4; mem_wdata  out  32.
REQ-013 mem_resp_valid  in  1; mem_rdata  in  32  memory response (loads and stores both respond).
REQ-014 out_valid  out  1; out_ready  in  1  writeback handshake.
REQ-015 out_data  out  32; out_rd  out  5; out_exc  out  1.

Function
REQ-016 FSM states: IDLE, REQ, WAIT, DONE; in_ready=1 only in IDLE.
REQ-017 IDLE, in_valid=1: capture inputs; aligned legal memory op -> REQ; otherwise -> DONE.
REQ-018 Legal: exactly one of isLoad/isStore, funct3 in the listed set for that class; neither set = pass-through.
REQ-019 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0; misaligned or illegal -> out_exc=1, out_data=captured addr, no memory request.
REQ-020 Pass-through: out_data=captured addr, out_exc=0, latency 1 cycle (out_valid the cycle after acceptance).
REQ-021 REQ: mem_req_valid=1 with all mem_* stable until mem_req_ready=1; then -> WAIT.
REQ-022 mem_addr={addr[31:2],2'b00}; mem_wen=isStore; loads drive mem_wmask=0.
REQ-023 Store mask: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111.
REQ-024 Store data: B {4{wdata[7:0]}}; H {2{wdata[15:0]}}; W wdata.
REQ-025 WAIT: mem_resp_valid sampled only here (earliest the cycle after request handshake); on resp -> DONE, latching the result.
REQ-026 Load result: lane = rdata shifted right by 8*addr[1:0]; B/H sign-extend, BU/HU zero-extend, W unchanged.
REQ-027 Store result: out_data=0, out_rd=0.
REQ-028 DONE: out_valid=1, out_data/out_rd/out_exc stable until out_ready=1; then -> IDLE.
REQ-029 No new op accepted in the cycle DONE completes; next acceptance earliest the following cycle.
REQ-030 mem_resp_valid outside WAIT is ignored.

Reset
REQ-031 reset=1 -> state IDLE, in_ready=1 once released; mem_req_valid, mem_wen, mem_wmask, mem_addr, mem_wdata, out_valid, out_data, out_rd, out_exc all 0 immediately.
REQ-032 Reset mid-operation discards the in-flight op; a late response after release is ignored.

Verification
REQ-033 LB addr 0x80000003, mem_rdata 0x80FF1234 -> mem_addr 0x80000000, mem_wmask 0, out_data 0xFFFFFF80, out_rd = in_rd.
REQ-034 SH addr 0x80000102, wdata 0x0000ABCD -> mem_wen 1, mem_wmask 4'b1100, mem_wdata 0xABCDABCD, out_data 0.
REQ-035 LW addr 0x80000002 -> no mem_req_valid; out_valid next cycle with out_exc 1, out_data 0x80000002.
REQ-036 mem_req_ready low 3 cycles, then out_ready low 2 cycles -> mem_* and out_* held stable; exactly one request issued and one writeback.
REQ-037 reset asserted in WAIT -> all outputs 0 in the same cycle; a response one cycle after release produces no out_valid.
REQ-038 Neither isLoad nor isStore, addr 0x12345678 -> out_data 0x12345678, out_exc 0, out_valid one cycle after acceptance.
